// File: rtl/fetch_align_queue_pkg.sv
// Shared constants for the fetch/align queue and the downstream decode block:
// RVC quadrants, instruction-length decode fields and the defined-illegal parcel.
package fetch_align_queue_pkg;

  localparam logic [1:0]  RVC_Q0         = 2'b00;
  localparam logic [1:0]  RVC_Q1         = 2'b01;
  localparam logic [1:0]  RVC_Q2         = 2'b10;
  localparam logic [1:0]  LEN32_OP       = 2'b11;
  localparam logic [2:0]  LEN48_OP       = 3'b111;
  localparam logic [15:0] ILLEGAL_PARCEL = 16'h0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
    logic        illegal;
  } instr_slot_t;

  function automatic logic is_wide(input logic [15:0] p);
    return p[1:0] == LEN32_OP;
  endfunction

  // 48-bit and longer encodings are flagged but still consumed as 32-bit.
  function automatic logic is_illegal(input logic [15:0] p0, input logic [15:0] p1);
    if (!is_wide(p0)) return p0 == ILLEGAL_PARCEL;
    return ({p1, p0} == 32'h0) || (p0[4:2] == LEN48_OP);
  endfunction

endpackage

// File: rtl/fetch_align_queue_parcel_fifo.sv
// DEPTH-entry circular parcel buffer; head/head+1 view includes this cycle's
// push data so a freshly fetched word can be consumed with no extra bubble.
module fetch_align_queue_parcel_fifo #(
  parameter int NPARCEL = 2,
  parameter int DEPTH   = 8,
  parameter int AW      = $clog2(DEPTH),
  parameter int CW      = AW + 1,
  parameter int PNW     = $clog2(NPARCEL + 1)
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     clr,
  input  logic [PNW-1:0]           push_n,
  input  logic [NPARCEL-1:0][15:0] push_data,
  input  logic [1:0]               pop_n,
  output logic [15:0]              head0,
  output logic [15:0]              head1,
  output logic [CW-1:0]            count,
  output logic [CW-1:0]            avail
);

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0]          head, tail;
  logic [1:0][15:0]       view;

  always_ff @(posedge gclk) begin
    if (!clr)
      for (int i = 0; i < NPARCEL; i++)
        if (PNW'(i) < push_n) mem[tail + AW'(i)] <= push_data[i];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + AW'(push_n);
      head  <= head + AW'(pop_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Slots beyond the stored count come straight from the incoming word.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      view[i] = mem[head + AW'(i)];
      if (CW'(i) >= count) begin
        view[i] = '0;
        for (int j = 0; j < NPARCEL; j++)
          if (count + CW'(j) == CW'(i)) view[i] = push_data[j];
      end
    end
  end

  assign head0 = view[0];
  assign head1 = view[1];
  assign avail = count + CW'(push_n);

endmodule

// File: rtl/fetch_align_queue.sv
// Fetch/align buffer: queues fetch-word parcels and presents one aligned
// RV32I/RVC instruction per cycle from a registered skid slot.
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int          NPARCEL  = 2,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_flush,
  input  logic [31:0]            I_flush_pc,
  input  logic                   I_fetch_valid,
  input  logic [16*NPARCEL-1:0]  I_fetch_data,
  input  logic [31:0]            I_fetch_pc,
  output logic                   O_fetch_ready,
  output logic                   O_instr_valid,
  output logic [31:0]            O_instr,
  output logic [31:0]            O_instr_pc,
  output logic                   O_instr_compressed,
  output logic                   O_illegalflag,
  input  logic                   I_instr_ready
);

  localparam int          AW     = $clog2(DEPTH);
  localparam int          CW     = AW + 1;
  localparam int          PNW    = $clog2(NPARCEL + 1);
  localparam int          SKW    = $clog2(NPARCEL);
  localparam logic [31:0] WBYTES = 32'(2 * NPARCEL);
  localparam logic [31:0] PC0    = RESET_PC & ~32'd1;

  logic [31:0]              exp_addr, next_pc, flush_pc;
  logic [SKW-1:0]           skip;
  instr_slot_t              slot;
  logic [CW-1:0]            count, avail;
  logic [PNW-1:0]           push_n;
  logic [1:0]               pop_n;
  logic [NPARCEL-1:0][15:0] push_data;
  logic [15:0]              head0, head1;
  logic                     push_ok, load_en, wide, can_load;

  assign flush_pc      = I_flush_pc & ~32'd1;
  assign O_fetch_ready = (CW'(DEPTH) - count >= CW'(NPARCEL)) && !I_flush;
  // Stale words are still handshaken, just not pushed.
  assign push_ok       = I_fetch_valid && O_fetch_ready && (I_fetch_pc == exp_addr);
  assign push_n        = push_ok ? PNW'(NPARCEL - int'(skip)) : '0;

  always_comb begin
    for (int i = 0; i < NPARCEL; i++) begin
      push_data[i] = '0;
      for (int j = 0; j < NPARCEL; j++)
        if (j == i + int'(skip)) push_data[i] = I_fetch_data[16*j +: 16];
    end
  end

  assign wide     = is_wide(head0);
  assign can_load = wide ? (avail >= CW'(2)) : (avail >= CW'(1));
  assign load_en  = !slot.valid || I_instr_ready;
  assign pop_n    = (!I_flush && load_en && can_load) ? (wide ? 2'd2 : 2'd1) : 2'd0;

  fetch_align_queue_parcel_fifo #(.NPARCEL(NPARCEL), .DEPTH(DEPTH)) u_fifo (
    .gclk      (I_clk),
    .grst_n    (I_rst_n),
    .clr       (I_flush),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count),
    .avail     (avail)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      exp_addr <= RESET_PC & ~(WBYTES - 32'd1);
      skip     <= RESET_PC[SKW:1];
      next_pc  <= PC0;
      slot     <= '0;
      slot.pc  <= PC0;
    end else if (I_flush) begin
      exp_addr   <= flush_pc & ~(WBYTES - 32'd1);
      skip       <= flush_pc[SKW:1];
      next_pc    <= flush_pc;
      slot.valid <= 1'b0;
      slot.pc    <= flush_pc;
    end else begin
      if (push_ok) begin
        exp_addr <= exp_addr + WBYTES;
        skip     <= '0;
      end
      if (load_en) begin
        slot.valid <= can_load;
        if (can_load) begin
          slot.pc         <= next_pc;
          next_pc         <= next_pc + (wide ? 32'd4 : 32'd2);
          slot.instr      <= wide ? {head1, head0} : {16'h0, head0};
          slot.compressed <= !wide;
          slot.illegal    <= is_illegal(head0, head1);
        end
      end
    end
  end

  assign O_instr_valid      = slot.valid;
  assign O_instr            = slot.instr;
  assign O_instr_pc         = slot.pc;
  assign O_instr_compressed = slot.compressed;
  assign O_illegalflag      = slot.illegal;

endmodule

// File: tb/tb_fetch_align_queue.sv
// Bench for fetch_align_queue: parcel-queue reference model checked every
// cycle, plus directed scenarios with hand-computed instruction streams.
module tb_fetch_align_queue;
  localparam int          NP    = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h0;

  logic              I_clk = 0, I_rst_n = 0, I_flush = 0;
  logic [31:0]       I_flush_pc = 0, I_fetch_pc = 0;
  logic              I_fetch_valid = 0, I_instr_ready = 0;
  logic [16*NP-1:0]  I_fetch_data = 0;
  logic              O_fetch_ready, O_instr_valid, O_instr_compressed, O_illegalflag;
  logic [31:0]       O_instr, O_instr_pc;

  int errors = 0, checks = 0;

  fetch_align_queue #(.NPARCEL(NP), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_flush(I_flush), .I_flush_pc(I_flush_pc),
    .I_fetch_valid(I_fetch_valid), .I_fetch_data(I_fetch_data), .I_fetch_pc(I_fetch_pc),
    .O_fetch_ready(O_fetch_ready), .O_instr_valid(O_instr_valid), .O_instr(O_instr),
    .O_instr_pc(O_instr_pc), .O_instr_compressed(O_instr_compressed),
    .O_illegalflag(O_illegalflag), .I_instr_ready(I_instr_ready)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of parcels plus the visible output slot.
  logic [15:0] m_pq[$];
  logic [31:0] m_exp, m_pc, m_ipc, m_instr;
  int          m_skip;
  logic        m_v, m_c, m_i;

  function automatic logic m_ready();
    return (DEPTH - m_pq.size() >= NP) && !I_flush;
  endfunction

  task automatic model_step();
    logic [15:0] p0, p1;
    if (!I_rst_n || I_flush) begin
      m_pq.delete();
      m_v = 0;
      m_pc = (!I_rst_n ? RPC : I_flush_pc) & ~32'd1;
      m_ipc = m_pc;
      m_exp = m_pc & ~32'(2*NP-1);
      m_skip = int'(m_pc % (2*NP)) / 2;
      if (!I_rst_n) begin m_instr = 0; m_c = 0; m_i = 0; end
    end else begin
      if (I_fetch_valid && m_ready() && I_fetch_pc == m_exp) begin
        for (int k = m_skip; k < NP; k++) m_pq.push_back(I_fetch_data[16*k +: 16]);
        m_skip = 0;
        m_exp += 32'(2*NP);
      end
      if (!m_v || I_instr_ready) begin
        m_v = 0;
        if (m_pq.size() >= 1) begin
          p0 = m_pq[0];
          if (p0[1:0] != 2'b11) begin
            void'(m_pq.pop_front());
            m_v = 1; m_instr = {16'h0, p0}; m_c = 1; m_i = (p0 == 16'h0);
            m_ipc = m_pc; m_pc += 2;
          end else if (m_pq.size() >= 2) begin
            p1 = m_pq[1];
            void'(m_pq.pop_front()); void'(m_pq.pop_front());
            m_v = 1; m_instr = {p1, p0}; m_c = 0;
            m_i = ({p1, p0} == 32'h0) || (p0[4:2] == 3'b111);
            m_ipc = m_pc; m_pc += 4;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge I_clk or negedge I_rst_n);
    model_step();
  end

  typedef struct { logic [31:0] instr, pc; logic c, i; } ent_t;
  ent_t        log_q[$];
  logic        p_stall = 0;
  logic [31:0] p_instr, p_pc;
  logic        p_c, p_i;

  // Per-cycle compare against the model, hold check while stalled, and log of accepted instructions.
  initial forever begin
    @(negedge I_clk);
    if (I_rst_n) begin
      chk("instr_valid", O_instr_valid, m_v);
      chk("fetch_ready", O_fetch_ready, m_ready());
      if (m_v) begin
        chk("instr", O_instr, m_instr);
        chk("instr_pc", O_instr_pc, m_ipc);
        chk("compressed", O_instr_compressed, m_c);
        chk("illegal", O_illegalflag, m_i);
      end
      if (p_stall) begin
        chk("hold_valid", O_instr_valid, 1);
        chk("hold_instr", O_instr, p_instr);
        chk("hold_pc", O_instr_pc, p_pc);
        chk("hold_flags", {O_instr_compressed, O_illegalflag}, {p_c, p_i});
      end
      p_stall = O_instr_valid && !I_instr_ready && !I_flush;
      p_instr = O_instr; p_pc = O_instr_pc; p_c = O_instr_compressed; p_i = O_illegalflag;
      if (O_instr_valid && I_instr_ready)
        log_q.push_back('{O_instr, O_instr_pc, O_instr_compressed, O_illegalflag});
    end else p_stall = 0;
  end

  task automatic do_reset();
    @(posedge I_clk); #1;
    I_rst_n = 0; I_fetch_valid = 0; I_flush = 0; I_instr_ready = 0;
    #10 I_rst_n = 1;
    log_q.delete();
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] d);
    logic r;
    int   n = 0;
    I_fetch_valid = 1; I_fetch_pc = pc; I_fetch_data = d;
    do begin
      @(negedge I_clk); r = O_fetch_ready;
      @(posedge I_clk); #1; n++;
    end while (!r && n < 60);
    checks++;
    if (!r) begin errors++; $display("FAIL send_timeout: word at %h not accepted, expected acceptance", pc); end
    I_fetch_valid = 0;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    I_flush = 1; I_flush_pc = pc;
    @(posedge I_clk); #1;
    I_flush = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge I_clk);
    #1;
  endtask

  task automatic exp_ent(input int idx, input logic [31:0] instr, input logic [31:0] pc,
                         input logic c, input logic i);
    checks++;
    if (idx >= log_q.size()) begin
      errors++; $display("FAIL log_entry%0d: missing, expected instr %h", idx, instr);
    end else begin
      chk($sformatf("log%0d_instr", idx), log_q[idx].instr, instr);
      chk($sformatf("log%0d_pc", idx), log_q[idx].pc, pc);
      chk($sformatf("log%0d_flags", idx), {log_q[idx].c, log_q[idx].i}, {c, i});
    end
  endtask

  initial begin
    // Reset and idle
    do_reset();
    @(negedge I_clk);
    chk("rst_valid", O_instr_valid, 0);
    chk("rst_fetch_ready", O_fetch_ready, 1);
    chk("rst_pc", O_instr_pc, 32'h0);
    chk("rst_instr", O_instr, 32'h0);

    // Single 32-bit instruction, one-cycle bypass latency
    do_reset(); I_instr_ready = 1;
    send(32'h0, 32'h00A00093);
    @(negedge I_clk);
    chk("lat_valid", O_instr_valid, 1);
    chk("lat_instr", O_instr, 32'h00A00093);
    idle(4);
    chk("t2_count", log_q.size(), 1);
    exp_ent(0, 32'h00A00093, 32'h0, 0, 0);

    // Two compressed instructions in one word
    do_reset(); I_instr_ready = 1;
    send(32'h0, 32'h45014505);
    idle(4);
    chk("t3_count", log_q.size(), 2);
    exp_ent(0, 32'h00004505, 32'h0, 1, 0);
    exp_ent(1, 32'h00004501, 32'h2, 1, 0);

    // 32-bit instruction straddling two words
    do_reset(); I_instr_ready = 1;
    send(32'h0, 32'h00934505);
    send(32'h4, 32'h000100A0);
    idle(5);
    chk("t4_count", log_q.size(), 3);
    exp_ent(0, 32'h00004505, 32'h0, 1, 0);
    exp_ent(1, 32'h00A00093, 32'h2, 0, 0);
    exp_ent(2, 32'h00000001, 32'h6, 1, 0);

    // Flush to mid-word PC, stale word dropped, leading parcel skipped
    do_reset(); I_instr_ready = 1;
    do_flush(32'h102);
    send(32'h8, 32'hDEADBEEF);
    send(32'h100, 32'h45051234);
    idle(5);
    chk("t5_count", log_q.size(), 1);
    exp_ent(0, 32'h00004505, 32'h102, 1, 0);

    // Backpressure: queue fills, outputs hold, then drain with an illegal parcel
    do_reset(); I_instr_ready = 0;
    for (int m = 0; m < 4; m++)
      send(32'(4*m), {16'(1 + 4*(2*m+1)), 16'(1 + 4*(2*m))});
    @(negedge I_clk);
    chk("full_fetch_ready", O_fetch_ready, 0);
    chk("stall_instr", O_instr, 32'h1);
    chk("stall_pc", O_instr_pc, 32'h0);
    fork
      begin
        for (int m = 4; m < 6; m++)
          send(32'(4*m), {16'(1 + 4*(2*m+1)), 16'(1 + 4*(2*m))});
        send(32'd24, 32'h00310000);
      end
      begin
        repeat (4) @(negedge I_clk);
        @(posedge I_clk); #1;
        I_instr_ready = 1;
      end
    join
    idle(20);
    chk("t6_count", log_q.size(), 14);
    for (int k = 0; k < 12; k++) exp_ent(k, 32'(1 + 4*k), 32'(2*k), 1, 0);
    exp_ent(12, 32'h0, 32'd24, 1, 1);
    exp_ent(13, 32'h31, 32'd26, 1, 0);

    // Asynchronous reset mid-stream
    do_reset(); I_instr_ready = 0;
    send(32'h0, 32'h45014505);
    send(32'h4, 32'h45014505);
    @(posedge I_clk); #3;
    I_rst_n = 0;
    #1;
    chk("async_rst_valid", O_instr_valid, 0);
    chk("async_rst_pc", O_instr_pc, 32'h0);
    chk("async_rst_fetch_ready", O_fetch_ready, 1);
    #3 I_rst_n = 1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
